// File: rtl/extreme_point_tracker.sv
// Per-frame extreme-point tracker: top/bottom/left/right foreground pixels, centre sums, orientation.
// Optional saturating hit counter and MIN_PIX threshold enabled by defining EXTREME_PIXEL_COUNT_EN.
module extreme_point_tracker #(
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 10,
  parameter int unsigned X_MAX    = 639,
  parameter int unsigned Y_MAX    = 479,
  parameter bit          FG_LEVEL = 1'b0
`ifdef EXTREME_PIXEL_COUNT_EN
  ,
  parameter int unsigned CNT_W    = 19,
  parameter int unsigned MIN_PIX  = 1
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           new_frm,
  input  logic           frm_done,
  input  logic           pix_valid,
  input  logic           pix_data,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  output logic [X_W-1:0] top_x,
  output logic [Y_W-1:0] top_y,
  output logic [X_W-1:0] bottom_x,
  output logic [Y_W-1:0] bottom_y,
  output logic [X_W-1:0] left_x,
  output logic [Y_W-1:0] left_y,
  output logic [X_W-1:0] right_x,
  output logic [Y_W-1:0] right_y,
  output logic [X_W+1:0] centre_sum_x,
  output logic [Y_W+1:0] centre_sum_y,
  output logic [X_W-1:0] angle_dx,
  output logic [Y_W-1:0] angle_dy,
  output logic           rot_dir,
  output logic           obj_found,
  output logic           res_valid,
  output logic           busy
`ifdef EXTREME_PIXEL_COUNT_EN
  ,
  output logic [CNT_W-1:0] pix_count
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, CALC, PUB} state_t;

  localparam logic [X_W-1:0] XS = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YS = Y_W'(Y_MAX);

  state_t state, next_state;
  logic new_frm_r1, new_frm_r2, start, hit, load_acc, upd, pub_en;
  logic [X_W-1:0] top_x_acc, bottom_x_acc, left_x_acc, right_x_acc;
  logic [Y_W-1:0] top_y_acc, bottom_y_acc, left_y_acc, right_y_acc;
  logic found_acc, found_now;
  logic [X_W-1:0] d1x, calc_dx;
  logic [Y_W-1:0] d1y, calc_dy;
  logic calc_rot;
  logic [X_W+1:0] calc_sum_x;
  logic [Y_W+1:0] calc_sum_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_frm_r1 <= 1'b0;
      new_frm_r2 <= 1'b0;
    end else begin
      new_frm_r1 <= new_frm;
      new_frm_r2 <= new_frm_r1;
    end
  end

  assign start    = new_frm_r1 & ~new_frm_r2;
  assign hit      = pix_valid && (pix_data == FG_LEVEL);
  // A start seen in CALC is dropped; any other start opens a fresh frame.
  assign load_acc = start && (state != CALC);
  assign upd      = hit && (state == ACCUM) && !start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (!start && frm_done) next_state = CALC;
      CALC:    next_state = PUB;
      PUB:     next_state = start ? ACCUM : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == ACCUM) || (state == CALC);
    pub_en = (state == CALC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_x_acc    <= '0; top_y_acc    <= '0;
      bottom_x_acc <= '0; bottom_y_acc <= '0;
      left_x_acc   <= '0; left_y_acc   <= '0;
      right_x_acc  <= '0; right_y_acc  <= '0;
      found_acc    <= 1'b0;
    end else if (load_acc) begin
      top_x_acc    <= '0; top_y_acc    <= YS;
      bottom_x_acc <= XS; bottom_y_acc <= '0;
      left_x_acc   <= XS; left_y_acc   <= YS;
      right_x_acc  <= '0; right_y_acc  <= '0;
      found_acc    <= 1'b0;
    end else if (upd) begin
      if (pix_y < top_y_acc || (pix_y == top_y_acc && pix_x > top_x_acc)) begin
        top_x_acc <= pix_x; top_y_acc <= pix_y;
      end
      if (pix_y > bottom_y_acc || (pix_y == bottom_y_acc && pix_x < bottom_x_acc)) begin
        bottom_x_acc <= pix_x; bottom_y_acc <= pix_y;
      end
      if (pix_x < left_x_acc || (pix_x == left_x_acc && pix_y < left_y_acc)) begin
        left_x_acc <= pix_x; left_y_acc <= pix_y;
      end
      if (pix_x > right_x_acc || (pix_x == right_x_acc && pix_y > right_y_acc)) begin
        right_x_acc <= pix_x; right_y_acc <= pix_y;
      end
      found_acc <= 1'b1;
    end
  end

`ifdef EXTREME_PIXEL_COUNT_EN
  logic [CNT_W-1:0] cnt_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_acc <= '0;
    else if (load_acc)              cnt_acc <= '0;
    else if (upd && cnt_acc != '1)  cnt_acc <= cnt_acc + 1'b1;
  end

  assign found_now = (32'(cnt_acc) >= MIN_PIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pix_count <= '0;
    else if (pub_en) pix_count <= cnt_acc;
  end
`else
  assign found_now = found_acc;
`endif

  // Differences are deliberately modulo 2^W so the sentinel-only frame wraps like the old hardware.
  always_comb begin
    d1x        = top_x_acc - left_x_acc;
    d1y        = left_y_acc - top_y_acc;
    calc_sum_x = {2'b00, top_x_acc} + {2'b00, bottom_x_acc} + {2'b00, left_x_acc} + {2'b00, right_x_acc};
    calc_sum_y = {2'b00, top_y_acc} + {2'b00, bottom_y_acc} + {2'b00, left_y_acc} + {2'b00, right_y_acc};
    if (32'(d1y) < 32'(d1x)) begin
      calc_dx  = d1x;
      calc_dy  = d1y;
      calc_rot = 1'b1;
    end else begin
      calc_dx  = right_x_acc - top_x_acc;
      calc_dy  = right_y_acc - top_y_acc;
      calc_rot = 1'b0;
    end
  end

  // Published set loads on the CALC->PUB edge so res_valid and the data appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_x <= '0; top_y <= '0; bottom_x <= '0; bottom_y <= '0;
      left_x <= '0; left_y <= '0; right_x <= '0; right_y <= '0;
      centre_sum_x <= '0; centre_sum_y <= '0;
      angle_dx <= '0; angle_dy <= '0; rot_dir <= 1'b0;
      obj_found <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= pub_en;
      if (pub_en) begin
        top_x <= top_x_acc;       top_y <= top_y_acc;
        bottom_x <= bottom_x_acc; bottom_y <= bottom_y_acc;
        left_x <= left_x_acc;     left_y <= left_y_acc;
        right_x <= right_x_acc;   right_y <= right_y_acc;
        centre_sum_x <= calc_sum_x;
        centre_sum_y <= calc_sum_y;
        angle_dx <= calc_dx;
        angle_dy <= calc_dy;
        rot_dir <= calc_rot;
        obj_found <= found_now;
      end
    end
  end

endmodule
